// File: rtl/dly_line.sv
// ----------------------------------------------------------------------------
// dly_line : parametrised, enable-gated delay line with per-stage valid.
//
// A WIDTH-bit sample plus its valid flag enters stage 0 on every enabled edge
// and shifts one stage per enabled edge, leaving after DEPTH enabled edges.
// Bubbles are stored with zero data, so an invalid stage always reads as 0.
// A registered occupancy count tracks how many stages hold valid samples.
//
// Optional feature macro: DLY_LINE_TAP_EN
//   When defined, a combinational tap mux exposes any stage selected by
//   dly_line_iport_tap; out-of-range selects read back as zero/invalid.
//
// Ports:
//   dly_line_cport_clk      in   1      clock, rising edge
//   dly_line_cport_rst      in   1      synchronous active-high reset
//   dly_line_cport_en       in   1      advance enable (0 = hold)
//   dly_line_cport_flush    in   1      synchronous clear, beats enable
//   dly_line_iport_d        in   WIDTH  input sample
//   dly_line_iport_vld      in   1      input sample valid
//   dly_line_iport_tap      in   TAP_W  tap stage select   (DLY_LINE_TAP_EN)
//   dly_line_oport_q        out  WIDTH  data of stage DEPTH-1
//   dly_line_oport_vld      out  1      valid of stage DEPTH-1
//   dly_line_oport_tap_q    out  WIDTH  data of tapped stage (DLY_LINE_TAP_EN)
//   dly_line_oport_tap_vld  out  1      valid of tapped stage (DLY_LINE_TAP_EN)
//   dly_line_oport_cnt      out  CNT_W  number of valid stages, 0..DEPTH
// ----------------------------------------------------------------------------
module dly_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             dly_line_cport_clk,
    input  logic             dly_line_cport_rst,
    input  logic             dly_line_cport_en,
    input  logic             dly_line_cport_flush,
    input  logic [WIDTH-1:0] dly_line_iport_d,
    input  logic             dly_line_iport_vld,
`ifdef DLY_LINE_TAP_EN
    input  logic [TAP_W-1:0] dly_line_iport_tap,
`endif
    output logic [WIDTH-1:0] dly_line_oport_q,
    output logic             dly_line_oport_vld,
`ifdef DLY_LINE_TAP_EN
    output logic [WIDTH-1:0] dly_line_oport_tap_q,
    output logic             dly_line_oport_tap_vld,
`endif
    output logic [CNT_W-1:0] dly_line_oport_cnt
);

    // Occupancy is recomputed from the next valid vector rather than
    // incremented, so it can never drift or wrap.
    function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    logic [DEPTH-1:0][WIDTH-1:0] data_p;
    logic [DEPTH-1:0]            vld_p;
    logic [CNT_W-1:0]            cnt_p;

    logic [DEPTH-1:0][WIDTH-1:0] data_nxt;
    logic [DEPTH-1:0]            vld_nxt;

    // ---- next-state: flush > enable > hold -----------------------------------
    always_comb begin
        data_nxt = data_p;
        vld_nxt  = vld_p;
        if (dly_line_cport_flush) begin
            data_nxt = '0;
            vld_nxt  = '0;
        end else if (dly_line_cport_en) begin
            // Bubbles enter with zero data so the output reads 0 when invalid.
            data_nxt[0] = dly_line_iport_vld ? dly_line_iport_d : '0;
            vld_nxt[0]  = dly_line_iport_vld;
            for (int i = 1; i < DEPTH; i++) begin
                data_nxt[i] = data_p[i-1];
                vld_nxt[i]  = vld_p[i-1];
            end
        end
    end

    // ---- stage registers ------------------------------------------------------
    always_ff @(posedge dly_line_cport_clk) begin
        if (dly_line_cport_rst) begin
            data_p <= '0;
            vld_p  <= '0;
            cnt_p  <= '0;
        end else begin
            data_p <= data_nxt;
            vld_p  <= vld_nxt;
            cnt_p  <= popcount(vld_nxt);
        end
    end

    assign dly_line_oport_q   = data_p[DEPTH-1];
    assign dly_line_oport_vld = vld_p[DEPTH-1];
    assign dly_line_oport_cnt = cnt_p;

`ifdef DLY_LINE_TAP_EN
    // ---- tap mux: select compared per stage so out-of-range reads as zero -----
    always_comb begin
        dly_line_oport_tap_q   = '0;
        dly_line_oport_tap_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (dly_line_iport_tap == i[TAP_W-1:0]) begin
                dly_line_oport_tap_q   = data_p[i];
                dly_line_oport_tap_vld = vld_p[i];
            end
        end
    end
`endif

endmodule
